// File: rtl/sdm_dec.sv
// sdm_dec - decimating averager placed directly after sdm_rx.
//
// Takes samples from sdm_rx through its full/pop toggle handshake, sums
// 2**LOG2R of them, then writes the average into a one-deep output register.
// That register is read through the same full/pop toggle handshake.
//
// Optional build macro: SDM_DEC_ROUND_EN
//   defined   : result = (acc + 2**(LOG2R-1)) >>> LOG2R  (round half up)
//   undefined : result = acc >>> LOG2R                   (truncate toward -inf)
// Handshake and timing are the same in both builds.
//
// Ports:
//   clk      system clock, all logic on posedge
//   rstn     asynchronous active-low reset
//   setn     synchronous enable; low parks the FSM in IDLE and drops acc/cnt
//   clear    synchronous clear of acc, cnt, full and ovf
//   in_full  sdm_rx full status
//   in_data  sdm_rx read data, signed, DMSB+1 bits
//   in_pop   toggle to sdm_rx; each level change consumes one sample
//   full     output register holds an unread result
//   pop      toggle from the reader; each level change acknowledges the result
//   rdata    averaged result, signed, DMSB+1 bits
//   ovf      sticky flag: a result was dropped because full was still set
//   xst      FSM state (0 IDLE, 1 WAIT, 2 TAKE, 3 DUMP)
//   cst      sample count within the current frame
module sdm_dec #(
  parameter int DMSB  = 3,
  parameter int LOG2R = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             setn,
  input  logic             clear,
  input  logic             in_full,
  input  logic [DMSB:0]    in_data,
  output logic             in_pop,
  output logic             full,
  input  logic             pop,
  output logic [DMSB:0]    rdata,
  output logic             ovf,
  output logic [1:0]       xst,
  output logic [LOG2R-1:0] cst
);

  // The sum of R samples of DMSB+1 bits always fits in DMSB+1+LOG2R bits.
  localparam int AW = DMSB + 1 + LOG2R;
  // R-1 has all bits set, so it marks the last sample of a frame.
  localparam logic [LOG2R-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TAKE = 2'd2,
    DUMP = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [LOG2R-1:0]       cnt_q, cnt_d;
  logic                   in_pop_q, in_pop_d;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;
  logic [DMSB:0]          rdata_q, rdata_d;
  logic                   in_full_q;   // previous-cycle copy of in_full
  logic                   pop_q;       // previous-cycle copy of pop

  logic                   in_full_rise;
  logic                   pop_ack;
  logic signed [AW-1:0]   in_ext;
  logic signed [AW-1:0]   pre_shift;
  logic signed [AW-1:0]   shifted;
  logic [DMSB:0]          result;

  assign in_full_rise = in_full & ~in_full_q;
  assign pop_ack      = pop ^ pop_q;
  assign in_ext       = {{LOG2R{in_data[DMSB]}}, in_data};

`ifdef SDM_DEC_ROUND_EN
  // Add half an LSB of the output at full accumulator width. It cannot wrap,
  // because the largest sum plus R/2 is still below 2**(AW-1).
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (LOG2R - 1));
  assign pre_shift = acc_q + HALF;
`else
  assign pre_shift = acc_q;
`endif

  assign shifted = pre_shift >>> LOG2R;
  assign result  = shifted[DMSB:0];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    in_pop_d = in_pop_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;

    if (clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
      ovf_d   = 1'b0;
      state_d = setn ? WAIT : IDLE;
    end else begin
      // The acknowledge is applied before the DUMP check below. A result that
      // arrives in the same cycle as a read therefore loads and does not overflow.
      if (pop_ack) begin
        full_d = 1'b0;
      end

      if (!setn) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: state_d = WAIT;
          WAIT: begin
            if (in_full_rise) begin
              state_d = TAKE;
            end
          end
          TAKE: begin
            acc_d    = acc_q + in_ext;
            in_pop_d = ~in_pop_q;
            cnt_d    = cnt_q + 1'b1;
            state_d  = (cnt_q == CNT_LAST) ? DUMP : WAIT;
          end
          DUMP: begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = WAIT;
            if (!full_d) begin
              rdata_d = result;
              full_d  = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      in_pop_q  <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
      in_full_q <= 1'b0;
      pop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      in_pop_q  <= in_pop_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      in_full_q <= in_full;
      pop_q     <= pop;
    end
  end

  assign in_pop = in_pop_q;
  assign full   = full_q;
  assign ovf    = ovf_q;
  assign rdata  = rdata_q;
  assign xst    = state_q;
  assign cst    = cnt_q;

endmodule

// File: tb/tb_sdm_dec.sv
// Testbench for sdm_dec. It keeps a transaction-level model of the expected
// outputs (sample sums and averages plus output-register rules). It checks
// the DUT against that model on every settled negedge, and adds hand-computed
// literal expectations at the end of each scenario.
module tb_sdm_dec;

  localparam int DMSB  = 3;
  localparam int LOG2R = 2;
  localparam int R     = 1 << LOG2R;

  logic             clk = 1'b0;
  logic             rstn;
  logic             setn;
  logic             clear;
  logic             in_full;
  logic [DMSB:0]    in_data;
  logic             in_pop;
  logic             full;
  logic             pop;
  logic [DMSB:0]    rdata;
  logic             ovf;
  logic [1:0]       xst;
  logic [LOG2R-1:0] cst;

  sdm_dec #(.DMSB(DMSB), .LOG2R(LOG2R)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .setn    (setn),
    .clear   (clear),
    .in_full (in_full),
    .in_data (in_data),
    .in_pop  (in_pop),
    .full    (full),
    .pop     (pop),
    .rdata   (rdata),
    .ovf     (ovf),
    .xst     (xst),
    .cst     (cst)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model state
  bit chk_en = 1'b0;
  int m_in_pop, m_full, m_rdata, m_ovf, m_xst, m_cnt, m_sum;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected average of a frame sum, computed with plain integer arithmetic.
  function automatic int avg(input int s);
    int n, q;
`ifdef SDM_DEC_ROUND_EN
    n = s + R / 2;
`else
    n = s;
`endif
    q = n / R;
    if ((n % R != 0) && (n < 0)) q = q - 1;   // floor division
    return q;
  endfunction

  task automatic model_reset();
    m_in_pop = 0; m_full = 0; m_rdata = 0; m_ovf = 0;
    m_xst = 0; m_cnt = 0; m_sum = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_pop", int'(in_pop), m_in_pop);
      check("full",   int'(full),   m_full);
      check("rdata",  int'($signed(rdata)), m_rdata);
      check("ovf",    int'(ovf),    m_ovf);
      check("xst",    int'(xst),    m_xst);
      check("cst",    int'(cst),    m_cnt);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One sample: in_full high 1 cycle, then low 3 cycles. If ack is set, pop
  // toggles so the DUT sees it in the cycle after the TAKE (the DUMP cycle on
  // the last sample of a frame).
  task automatic feed(input int v, input bit ack);
    logic [31:0] vv;
    int res;
    vv = v;
    chk_en  = 1'b0;
    in_data = vv[DMSB:0];
    in_full = 1'b1;
    step(1);
    in_full = 1'b0;
    step(1);
    if (ack) pop = ~pop;
    step(2);
    if (ack) m_full = 0;
    m_in_pop = 1 - m_in_pop;
    m_sum += v;
    m_cnt++;
    if (m_cnt == R) begin
      res = avg(m_sum);
      if (m_full == 0) begin m_rdata = res; m_full = 1; end
      else m_ovf = 1;
      m_cnt = 0;
      m_sum = 0;
    end
    chk_en = 1'b1;
  endtask

  task automatic do_pop();
    chk_en = 1'b0;
    pop = ~pop;
    step(1);
    m_full = 0;
    chk_en = 1'b1;
  endtask

  task automatic do_clear();
    chk_en = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    m_full = 0; m_ovf = 0; m_cnt = 0; m_sum = 0;
    m_xst = setn ? 1 : 0;
    chk_en = 1'b1;
  endtask

  task automatic enable_after_reset();
    chk_en = 1'b0;
    rstn = 1'b1;
    setn = 1'b1;
    step(2);
    m_xst = 1;
    chk_en = 1'b1;
  endtask

  int exp_a, exp_b;

  initial begin
    rstn = 1'b0; setn = 1'b0; clear = 1'b0; in_full = 1'b0;
    in_data = '0; pop = 1'b0;
    model_reset();
    chk_en = 1'b1;
    step(3);
    check("reset_full", int'(full), 0);
    check("reset_inpop", int'(in_pop), 0);
    enable_after_reset();

    // Scenario 1: 3,3,3,3 -> 3
    for (int i = 0; i < 4; i++) feed(3, 1'b0);
    check("s1_rdata", int'($signed(rdata)), 3);
    check("s1_full", int'(full), 1);
    check("s1_cst", int'(cst), 0);
    check("s1_xst", int'(xst), 1);
    check("s1_inpop", int'(in_pop), 0);
    step(2);

    // Scenario 2: -1,-2,0,1
    do_pop();
    feed(-1, 1'b0); feed(-2, 1'b0); feed(0, 1'b0); feed(1, 1'b0);
`ifdef SDM_DEC_ROUND_EN
    exp_a = 0;
`else
    exp_a = -1;
`endif
    check("s2_rdata", int'($signed(rdata)), exp_a);
    check("s2_ovf", int'(ovf), 0);
    do_pop();

    // Scenario 3: in_full held high takes exactly one sample
    chk_en = 1'b0;
    in_data = 4'd6;
    in_full = 1'b1;
    step(2);
    m_in_pop = 1 - m_in_pop; m_cnt = 1; m_sum = 6;
    chk_en = 1'b1;
    step(8);
    check("s3_cst", int'(cst), 1);
    check("s3_inpop", int'(in_pop), 1);
    in_full = 1'b0;
    step(2);
    do_clear();
    step(1);

    // Scenario 4: overflow when the result is not read
    for (int i = 1; i <= 4; i++) feed(i, 1'b0);
    for (int i = 0; i < 4; i++) feed(5, 1'b0);
`ifdef SDM_DEC_ROUND_EN
    exp_b = 3;
`else
    exp_b = 2;
`endif
    check("s4_rdata", int'($signed(rdata)), exp_b);
    check("s4_full", int'(full), 1);
    check("s4_ovf", int'(ovf), 1);
    do_pop();
    do_clear();
    check("s4_clr_full", int'(full), 0);
    check("s4_clr_ovf", int'(ovf), 0);

    // Scenario 5: read acknowledge coincides with DUMP
    for (int i = 0; i < 4; i++) feed(2, 1'b0);
    check("s5_first", int'($signed(rdata)), 2);
    feed(4, 1'b0); feed(4, 1'b0); feed(4, 1'b0); feed(4, 1'b1);
    check("s5_rdata", int'($signed(rdata)), 4);
    check("s5_full", int'(full), 1);
    check("s5_ovf", int'(ovf), 0);
    do_pop();

    // Scenario 6: reset in the middle of a frame
    feed(-8, 1'b0); feed(-8, 1'b0);
    rstn = 1'b0;
    pop  = 1'b0;
    model_reset();
    step(3);
    enable_after_reset();
    for (int i = 0; i < 4; i++) feed(7, 1'b0);
    check("s6_rdata", int'($signed(rdata)), 7);
    check("s6_full", int'(full), 1);

    // Scenario 7: setn low in the middle of a frame
    feed(-8, 1'b0); feed(-8, 1'b0);
    chk_en = 1'b0;
    setn = 1'b0;
    step(1);
    m_cnt = 0; m_sum = 0; m_xst = 0;
    chk_en = 1'b1;
    step(2);
    check("s7_hold_full", int'(full), 1);
    check("s7_hold_rdata", int'($signed(rdata)), 7);
    chk_en = 1'b0;
    setn = 1'b1;
    step(2);
    m_xst = 1;
    chk_en = 1'b1;
    do_pop();
    for (int i = 0; i < 4; i++) feed(7, 1'b0);
    check("s7_rdata", int'($signed(rdata)), 7);
    check("s7_full", int'(full), 1);
    step(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
